if1_stage: RTL

IF1_STAGE -- requirements
Module: if1_stage

---
 rtl/if1_stage.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/if1_stage.sv
// IF1 fetch stage: 4-entry in-order buffer pairing IF0 entries with icache responses.
// Define IF1_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
`ifndef IF0_TO_IF1_BUS_WD
`define IF0_TO_IF1_BUS_WD 56
`endif
`ifndef IF1_TO_ID_BUS_WD
`define IF1_TO_ID_BUS_WD 88
`endif

module if1_stage (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_IF,
    input  logic [`IF0_TO_IF1_BUS_WD-1:0] if0_if1_bus,
    input  logic                          IF0_valid,
    output logic                          IF1_ready,
    input  logic                          req_fire,
    input  logic                          data_ok,
    input  logic [31:0]                   rdata,
    output logic                          id_valid,
    input  logic                          id_ready,
    output logic [`IF1_TO_ID_BUS_WD-1:0]  id_bus
`ifdef IF1_PERF_EN
    ,
    output logic [31:0]                   perf_fetch_cnt,
    output logic [31:0]                   perf_stall_cnt
`endif
);

    localparam int unsigned BusWd   = `IF0_TO_IF1_BUS_WD;
    localparam int unsigned Depth   = 4;
    localparam logic [31:0] ExcpNop = 32'h03400000;

    logic [BusWd-1:0] bus_q  [Depth];
    logic [BusWd-1:0] bus_d  [Depth];
    logic [31:0]      inst_q [Depth];
    logic [31:0]      inst_d [Depth];
    logic [Depth-1:0] done_q, done_d;
    logic [1:0]       head_q, head_d, tail_q, tail_d;
    logic [2:0]       count_q, count_d;
    logic [2:0]       outstanding_q, outstanding_d;
    logic [2:0]       drop_cnt_q, drop_cnt_d;

    logic       capture, pop, dropping, fill_ok, out_dec, cap_excp;
    logic       fill_hit;
    logic [1:0] fill_idx;

    assign capture   = IF0_valid & ~flush_IF;
    assign cap_excp  = if0_if1_bus[BusWd-1];
    assign id_valid  = (count_q != 3'd0) & done_q[head_q];
    assign id_bus    = {bus_q[head_q], inst_q[head_q]};
    assign IF1_ready = (count_q <= 3'd2);
    assign pop       = id_valid & id_ready & ~flush_IF;
    assign dropping  = data_ok & (drop_cnt_q != 3'd0);
    assign fill_ok   = data_ok & ~dropping;
    // Responses that arrive after reset are untracked; keep outstanding from wrapping below zero.
    assign out_dec   = data_ok & ((outstanding_q != 3'd0) | req_fire);

    // Oldest live entry still waiting on the cache.
    always_comb begin
        fill_hit = 1'b0;
        fill_idx = head_q;
        for (int i = 0; i < Depth; i++) begin
            if (!fill_hit && (3'(i) < count_q) && !done_q[head_q + 2'(i)]
                && !bus_q[head_q + 2'(i)][BusWd-1]) begin
                fill_hit = 1'b1;
                fill_idx = head_q + 2'(i);
            end
        end
    end

    always_comb begin
        bus_d         = bus_q;
        inst_d        = inst_q;
        done_d        = done_q;
        head_d        = head_q + {1'b0, pop};
        tail_d        = tail_q + {1'b0, capture};
        count_d       = count_q + {2'b0, capture} - {2'b0, pop};
        outstanding_d = outstanding_q + {2'b0, req_fire} - {2'b0, out_dec};
        drop_cnt_d    = dropping ? drop_cnt_q - 3'd1 : drop_cnt_q;

        if (capture) begin
            bus_d[tail_q]  = if0_if1_bus;
            inst_d[tail_q] = cap_excp ? ExcpNop : 32'h0;
            done_d[tail_q] = cap_excp;
        end

        if (fill_ok && fill_hit) begin
            inst_d[fill_idx] = rdata;
            done_d[fill_idx] = 1'b1;
        end else if (fill_ok && capture && !cap_excp) begin
            inst_d[tail_q] = rdata;
            done_d[tail_q] = 1'b1;
        end

        if (flush_IF) begin
            head_d     = 2'd0;
            tail_d     = 2'd0;
            count_d    = 3'd0;
            done_d     = '0;
            drop_cnt_d = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                bus_q[i]  <= '0;
                inst_q[i] <= '0;
            end
            done_q        <= '0;
            head_q        <= 2'd0;
            tail_q        <= 2'd0;
            count_q       <= 3'd0;
            outstanding_q <= 3'd0;
            drop_cnt_q    <= 3'd0;
        end else begin
            bus_q         <= bus_d;
            inst_q        <= inst_d;
            done_q        <= done_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

`ifndef SYNTHESIS
    // IF1_ready leaves a slot for the entry already in IF0; a fifth capture is a protocol bug.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            assert (count_q != 3'd4);
        end
    end
`endif

`ifdef IF1_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((count_q != 3'd0) && !done_q[head_q]) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
